// File: rtl/data_mem_if.sv
// data_mem_if: request/response bus between the MEM stage and the data memory.
interface data_mem_if #(parameter int ADDR_W = 32);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [1:0] req_size;
  logic req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic resp_valid;
  logic [31:0] resp_rdata;
  logic resp_err;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: four byte-lane data memory with sized stores/loads, extension and alignment checks.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 16384,
  parameter int ADDR_W      = 32,
  parameter int READ_LAT    = 1
) (
  input logic clk,
  input logic rst,
  data_mem_if.slave bus
);
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH_WORDS);
  localparam logic [1:0] LAST = 2'(READ_LAT - 2);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next;
  logic [1:0] cnt, cap_size, cap_lane;
  logic cap_we, cap_uns, cap_err, accept, err;
  logic [IW-1:0] idx, cap_idx;
  logic [3:0] we_lane;
  logic [31:0] wd, rd_word, ext;
  logic [15:0] half;
  logic [7:0] byte_v;
  assign bus.req_ready = state == IDLE && !rst;
  assign accept = bus.req_valid && bus.req_ready;
  assign err = bus.req_size == 2'b11
            || (bus.req_size == 2'b01 && bus.req_addr[0])
            || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
            || ({2'b00, bus.req_addr[ADDR_W-1:2]} >= LIMIT);
  // The accepting cycle addresses the arrays directly so stores land on the accept edge
  // and a READ_LAT=1 load is read on that same edge.
  assign idx = accept ? bus.req_addr[IW+1:2] : cap_idx;
  always_comb begin
    we_lane = !(accept && bus.req_we && !err) ? 4'b0000
            : bus.req_size == 2'b00 ? 4'b0001 << bus.req_addr[1:0]
            : bus.req_size == 2'b01 ? (bus.req_addr[1] ? 4'b1100 : 4'b0011)
            : 4'b1111;
    wd = bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}}
       : bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}}
       : bus.req_wdata;
  end
  for (genvar g = 0; g < 4; g++) begin : lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] q;
    always_ff @(posedge clk) begin
      if (we_lane[g]) mem[idx] <= wd[8*g +: 8];
      q <= mem[idx];
    end
  end
  assign rd_word = {lane[3].q, lane[2].q, lane[1].q, lane[0].q};
  always_comb begin
    half = cap_lane[1] ? rd_word[31:16] : rd_word[15:0];
    byte_v = rd_word[{cap_lane, 3'b000} +: 8];
    ext = cap_size == 2'b00 ? {{24{!cap_uns && byte_v[7]}}, byte_v}
        : cap_size == 2'b01 ? {{16{!cap_uns && half[15]}}, half}
        : rd_word;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 2'd0;
    end else begin
      state <= next;
      cnt <= state == WAIT ? cnt + 2'd1 : 2'd0;
    end
    if (accept) begin
      cap_we <= bus.req_we;
      cap_size <= bus.req_size;
      cap_uns <= bus.req_unsigned;
      cap_lane <= bus.req_addr[1:0];
      cap_idx <= bus.req_addr[IW+1:2];
      cap_err <= err;
    end
  end
  always_comb begin
    next = state == IDLE ? (accept ? ((bus.req_we || err || READ_LAT == 1) ? RESP : WAIT) : IDLE)
         : state == WAIT ? (cnt == LAST ? RESP : WAIT)
         : IDLE;
  end
  assign bus.resp_valid = state == RESP && !rst;
  assign bus.resp_err = bus.resp_valid && cap_err;
  assign bus.resp_rdata = (bus.resp_valid && !cap_err && !cap_we) ? ext : '0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized and directed checks of data_mem_ctrl against a byte-array model.
module tb_data_mem_ctrl;
  localparam int DEPTH = 64;
  localparam int LAT = 3;
  typedef struct {logic [31:0] d; logic e; int due;} exp_t;
  logic clk = 0, rst = 1;
  int cyc = 0, errors = 0, checks = 0;
  bit armed = 0;
  exp_t q[$];
  logic [7:0] mm [4*DEPTH];
  logic [31:0] last_d;
  logic last_e;
  data_mem_if #(.ADDR_W(32)) bus();
  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .READ_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (armed) begin
    chk("req_ready", 32'(bus.req_ready), 32'(!rst && q.size() == 0));
    if (rst) begin
      chk("rst_resp_valid", 32'(bus.resp_valid), 0);
      chk("rst_resp_rdata", bus.resp_rdata, 0);
    end else if (q.size() != 0 && cyc == q[0].due) begin
      chk("resp_valid", 32'(bus.resp_valid), 1);
      chk("resp_rdata", bus.resp_rdata, q[0].d);
      chk("resp_err", 32'(bus.resp_err), 32'(q[0].e));
      last_d = bus.resp_rdata;
      last_e = bus.resp_err;
      void'(q.pop_front());
    end else chk("resp_idle", 32'(bus.resp_valid), 0);
  end
  task automatic issue(bit we, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    int n = 0;
    bit err;
    last_d = 'x;
    last_e = 'x;
    bus.req_valid = 1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    do begin @(negedge clk); n++; end while (!bus.req_ready && n < 20);
    if (!bus.req_ready) begin
      errors++;
      $display("FAIL accept_timeout: req_ready stuck at %b, required 1", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
    bus.req_size = 2'($urandom); bus.req_unsigned = 1'($urandom); bus.req_we = 1'($urandom);
    err = sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 0) || (a / 4 >= DEPTH);
    e.d = 0;
    e.e = err;
    if (!err && we) for (int i = 0; i < (1 << sz); i++) mm[a + i] = wd[8*i +: 8];
    else if (!err) begin
      for (int i = 0; i < (1 << sz); i++) e.d[8*i +: 8] = mm[a + i];
      if (!uns && sz == 0 && e.d[7]) e.d[31:8] = '1;
      if (!uns && sz == 1 && e.d[15]) e.d[31:16] = '1;
    end
    e.due = cyc + ((err || we) ? 1 : LAT) - 1;
    q.push_back(e);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL resp_timeout: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
    #1;
  endtask
  task automatic req(bit we, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] wd);
    issue(we, sz, uns, a, wd);
    wait_done();
  endtask
  task automatic pin(string name, logic [31:0] d, logic e);
    chk(name, last_d, d);
    chk({name, "_err"}, 32'(last_e), 32'(e));
  endtask
  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0;
    bus.req_unsigned = 0; bus.req_addr = 0; bus.req_wdata = 0;
    @(posedge clk); #1 armed = 1;
    @(posedge clk); #1 rst = 0;
    for (int w = 0; w < DEPTH; w++) req(1, 2'b10, 0, 32'(4*w), $urandom);
    req(1, 2'b10, 0, 32'h10, 32'h8000_00FF);
    req(0, 2'b00, 0, 32'h10, 0); pin("lb_10", 32'hFFFF_FFFF, 0);
    req(0, 2'b00, 1, 32'h10, 0); pin("lbu_10", 32'h0000_00FF, 0);
    req(0, 2'b00, 0, 32'h13, 0); pin("lb_13", 32'hFFFF_FF80, 0);
    req(0, 2'b10, 0, 32'h10, 0); pin("lw_10", 32'h8000_00FF, 0);
    req(1, 2'b10, 0, 32'h20, 32'h1122_3344);
    req(1, 2'b01, 0, 32'h22, 32'h0000_BEEF);
    req(1, 2'b00, 0, 32'h20, 32'h0000_0055);
    req(0, 2'b10, 0, 32'h20, 0); pin("lw_20", 32'hBEEF_3355, 0);
    req(0, 2'b01, 1, 32'h22, 0); pin("lhu_22", 32'h0000_BEEF, 0);
    req(0, 2'b01, 0, 32'h21, 0); pin("lh_mis", 0, 1);
    req(0, 2'b10, 0, 32'h22, 0); pin("lw_mis", 0, 1);
    req(0, 2'b11, 0, 32'h20, 0); pin("size11", 0, 1);
    req(1, 2'b01, 0, 32'h23, 32'hFFFF); pin("sh_mis", 0, 1);
    req(0, 2'b10, 0, 32'h20, 0); pin("lw_20_kept", 32'hBEEF_3355, 0);
    req(0, 2'b10, 0, 32'(4*DEPTH), 0); pin("lw_range", 0, 1);
    req(1, 2'b00, 0, 32'(4*DEPTH - 1), 32'hA5); pin("sb_last", 0, 0);
    req(0, 2'b00, 1, 32'(4*DEPTH - 1), 0); pin("lbu_last", 32'h0000_00A5, 0);
    req(1, 2'b10, 0, 32'h30, 32'hCAFE_F00D);
    issue(0, 2'b10, 0, 32'h30, 0);
    rst = 1;
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    req(0, 2'b10, 0, 32'h30, 0); pin("lw_after_rst", 32'hCAFE_F00D, 0);
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0: a = 32'(4*DEPTH) + $urandom_range(0, 7);
        1: a = $urandom;
        default: a = $urandom_range(0, 4*DEPTH - 1);
      endcase
      req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t, required finish earlier", $time);
    $fatal(1);
  end
endmodule
